// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcodes, FSM states, ALU codes and control word for the multicycle MIPS core.
// MIPS_MC_JUMP_BNE_EN turns on decode of bne and j (otherwise both are illegal).
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_SLT = 6'h2A;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                           ALU_SLT = 3'd4;
    localparam logic [1:0] SRCB_REG = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM2 = 2'd3;
    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;

`ifdef MIPS_MC_JUMP_BNE_EN
    localparam bit JB_EN = 1'b1;
`else
    localparam bit JB_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] fn);
        return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
               fn == FN_SLT ? ALU_SLT : ALU_ADD;
    endfunction

    function automatic state_t decode_state(input logic [5:0] op, input logic [5:0] fn);
        state_t s;
        s = S_HALT;
        case (op)
            OP_RTYPE:     s = funct_ok(fn) ? S_EXEC : S_HALT;
            OP_LW, OP_SW: s = S_MEMADR;
            OP_BEQ:       s = S_BRANCH;
            OP_BNE:       s = JB_EN ? S_BRANCH : S_HALT;
            OP_J:         s = JB_EN ? S_JUMP : S_HALT;
            OP_ADDI:      s = S_ADDIEX;
            default:      s = S_HALT;
        endcase
        return s;
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_write  = 1'b1;
                c.ir_write  = 1'b1;
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM2;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.iord    = 1'b1;
                c.mem_req = 1'b1;
            end
            S_MEMWR: begin
                c.iord    = 1'b1;
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = funct_op(fn);
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.branch    = 1'b1;
                c.branch_ne = op == OP_BNE;
                c.pc_src    = PC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_JUMP;
            end
            default: c.pc_src = PC_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: main-control FSM; registers the control word of the state being entered.
// MIPS_MC_JUMP_BNE_EN (through the package decode) adds the JUMP state and bne.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl,
    output logic       halted
);

    state_t state, next;
    logic   done;

    assign done = ctrl.mem_req & mem_ready_i;

    always_comb begin
        next = state;
        case (state)
            S_FETCH:  next = done ? S_DECODE : S_FETCH;
            S_DECODE: next = decode_state(opcode, funct);
            S_MEMADR: next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next = done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next = done ? S_FETCH : S_MEMWR;
            S_EXEC:   next = S_ALUWB;
            S_ADDIEX: next = S_ADDIWB;
            S_HALT:   next = S_HALT;
            default:  next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl   <= ctrl_of(S_FETCH, opcode, funct);
            halted <= 1'b0;
        end else begin
            state  <= next;
            ctrl   <= ctrl_of(next, opcode, funct);
            halted <= next == S_HALT;
        end
    end

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, addi) on one req/ready port.
// Define MIPS_MC_JUMP_BNE_EN to also execute bne and j.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   GPIO_W   = 8,
    parameter int unsigned   GPIO_REG = 9
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              halted_o
);

    ctrl_t             cw;
    logic [AW-1:0]     pc, pc_next, jump_target;
    logic [31:0]       ir, a, b, alu_out, mdr, imm, src_a, src_b, alu_y, wdata;
    logic [31:0]       regs [32];
    logic [4:0]        waddr;
    logic [GPIO_W-1:0] gpio;
    logic              mem_done, take, pc_en;

    mips_mc_ctrl u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .opcode      (ir[31:26]),
        .funct       (ir[5:0]),
        .mem_ready_i (mem_ready_i),
        .ctrl        (cw),
        .halted      (halted_o)
    );

    assign imm         = {{16{ir[15]}}, ir[15:0]};
    assign mem_done    = cw.mem_req & mem_ready_i;
    assign take        = cw.branch & ((a == b) ^ cw.branch_ne);
    assign pc_en       = (cw.pc_write & (~cw.mem_req | mem_ready_i)) | take;
    // Upper PC bits survive a jump only when AW exceeds the 28-bit jump field.
    assign jump_target = AW'({ir[25:0], 2'b00}) | (pc & ~AW'({28{1'b1}}));

    assign src_a = cw.alu_src_a ? a : 32'(pc);
    assign src_b = cw.alu_src_b == SRCB_REG ? b : cw.alu_src_b == SRCB_FOUR ? 32'd4 :
                   cw.alu_src_b == SRCB_IMM ? imm : imm << 2;
    assign alu_y = cw.alu_op == ALU_SUB ? src_a - src_b :
                   cw.alu_op == ALU_AND ? src_a & src_b :
                   cw.alu_op == ALU_OR  ? src_a | src_b :
                   cw.alu_op == ALU_SLT ? {31'd0, $signed(src_a) < $signed(src_b)} : src_a + src_b;

    assign pc_next = cw.pc_src == PC_ALUOUT ? alu_out[AW-1:0] :
                     cw.pc_src == PC_JUMP ? jump_target : alu_y[AW-1:0];
    assign waddr   = cw.reg_dst ? ir[15:11] : ir[20:16];
    assign wdata   = cw.mem_to_reg ? mdr : alu_out;

    assign mem_req_o   = cw.mem_req & ~reset;
    assign mem_we_o    = cw.mem_we & ~reset;
    assign mem_addr_o  = cw.iord ? alu_out[AW-1:0] : pc;
    assign mem_wdata_o = b;
    assign gpio_o      = gpio;

    // A, B and ALUOut freeze while a request is open so address and store data stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            gpio    <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (pc_en) pc <= pc_next;
            if (cw.ir_write && mem_done) ir <= mem_rdata_i;
            if (cw.iord && mem_done && !cw.mem_we) mdr <= mem_rdata_i;
            if (!cw.mem_req) begin
                a       <= regs[ir[25:21]];
                b       <= regs[ir[20:16]];
                alu_out <= alu_y;
            end
            if (cw.reg_write && waddr != 5'd0) begin
                regs[waddr] <= wdata;
                if (waddr == 5'(GPIO_REG)) gpio <= wdata[GPIO_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed programs for mips_mc_core with a memory-transaction scoreboard.
// Define MIPS_MC_JUMP_BNE_EN to expect j to execute instead of halting.
module tb_mips_mc_core;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
    localparam logic [5:0] F_ADD = 6'h20, F_SLT = 6'h2A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req, we, ready, halted;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  gpio;
    logic [31:0] mem [64];
    int          wait_n = 0;
    int          cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    txn_t        exp_q [$];

    mips_mc_core dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req_o   (req),
        .mem_we_o    (we),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .mem_rdata_i (rdata),
        .mem_ready_i (ready),
        .gpio_o      (gpio),
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    assign ready = req && cnt == wait_n;
    assign rdata = mem[addr[7:2]];

    always @(posedge clk) begin
        if (req && ready && we) mem[addr[7:2]] = wdata;
        cnt <= (reset || !req || ready) ? 0 : cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        txn_t e;
        if (req && ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("txn_we", {31'd0, we}, {31'd0, e.we});
            chk("txn_addr", addr, e.addr);
            if (e.we) chk("txn_wdata", wdata, e.wdata);
        end
    end

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d = 32'd0);
        exp_q.push_back('{we: w, addr: a, wdata: d});
    endtask

    task automatic rst_on();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    endtask

    task automatic rst_off();
        reset = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_mem(input logic w, input logic [31:0] a, input string tag);
        int n = 0;
        while (!(req && we == w && addr == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, n < 200}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state, then addi/add with zero-wait memory
        rst_on();
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_gpio", gpio, 0);
        chk("rst_halted", halted, 0);
        mem[0] = i_op(ADDI, 0, 8, 5);
        mem[1] = r_op(8, 8, 9, F_ADD);
        push(0, 0);
        push(0, 4);
        rst_off();
        chk("first_req", req, 1);
        chk("first_addr", addr, 0);
        chk("first_we", we, 0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("gpio_cycle7", gpio, 0);
        @(negedge clk);
        chk("gpio_cycle8", gpio, 8'h0A);
        chk("pc8_req", req, 1);
        chk("pc8_addr", addr, 8);
        drain("drain_add");

        // sw then lw with three wait cycles each
        rst_on();
        wait_n = 3;
        mem[0] = i_op(ADDI, 0, 8, 5);
        mem[1] = i_op(SW, 0, 8, 16);
        mem[2] = i_op(LW, 0, 10, 16);
        mem[3] = i_op(SW, 0, 10, 20);
        push(0, 0);
        push(0, 4);
        push(1, 16, 5);
        push(0, 8);
        push(0, 16);
        push(0, 12);
        push(1, 20, 5);
        rst_off();
        wait_mem(1, 16, "sw_seen");
        for (int i = 0; i < 4; i++) begin
            chk("sw_req", req, 1);
            chk("sw_we", we, 1);
            chk("sw_addr", addr, 16);
            chk("sw_wdata", wdata, 5);
            @(negedge clk);
        end
        wait_mem(0, 16, "lw_seen");
        for (int i = 0; i < 4; i++) begin
            chk("lw_req", req, 1);
            chk("lw_we", we, 0);
            chk("lw_addr", addr, 16);
            @(negedge clk);
        end
        drain("drain_swlw");
        chk("mem16", mem[4], 5);
        chk("mem20_lw_result", mem[5], 5);

        // beq taken to itself, then not taken
        rst_on();
        wait_n = 0;
        mem[0] = i_op(ADDI, 0, 8, 5);
        mem[1] = i_op(BEQ, 8, 8, -1);
        push(0, 0);
        push(0, 4);
        push(0, 4);
        push(0, 4);
        rst_off();
        drain("beq_taken");
        rst_on();
        mem[0] = i_op(ADDI, 0, 8, 5);
        mem[1] = i_op(ADDI, 0, 9, 6);
        mem[2] = i_op(BEQ, 8, 9, -1);
        push(0, 0);
        push(0, 4);
        push(0, 8);
        push(0, 12);
        rst_off();
        drain("beq_not_taken");

        // illegal opcode halts until reset
        rst_on();
        mem[0] = 32'hFC00_0000;
        push(0, 0);
        rst_off();
        drain("ill_fetch");
        repeat (2) @(negedge clk);
        chk("ill_halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            chk("halt_no_req", req, 0);
            @(negedge clk);
        end
        rst_on();
        chk("halt_cleared", halted, 0);
        push(0, 0);
        rst_off();
        chk("refetch_req", req, 1);
        chk("refetch_addr", addr, 0);
        drain("refetch");

        // $0 stays zero, signed slt drives gpio
        rst_on();
        mem[0] = i_op(ADDI, 0, 8, 5);
        mem[1] = i_op(ADDI, 0, 0, 7);
        mem[2] = i_op(ADDI, 0, 9, -3);
        mem[3] = r_op(9, 8, 9, F_SLT);
        mem[4] = i_op(SW, 0, 0, 24);
        mem[6] = 32'hDEAD_BEEF;
        push(0, 0);
        push(0, 4);
        push(0, 8);
        push(0, 12);
        push(0, 16);
        push(1, 24, 0);
        rst_off();
        drain("drain_slt");
        chk("slt_gpio", gpio, 8'h01);
        chk("zero_reg_store", mem[6], 0);

        // reset during a lw wait aborts the register write
        rst_on();
        wait_n = 2;
        mem[0] = i_op(LW, 0, 9, 16);
        mem[4] = 32'h77;
        push(0, 0);
        rst_off();
        wait_mem(0, 16, "lw_wait");
        @(negedge clk);
        rst_on();
        chk("abort_gpio_rst", gpio, 0);
        wait_n = 0;
        mem[0] = i_op(SW, 0, 9, 20);
        mem[5] = 32'h55;
        push(0, 0);
        push(1, 20, 0);
        rst_off();
        drain("drain_abort");
        chk("abort_reg", mem[5], 0);
        chk("abort_gpio", gpio, 0);

        // j 0x40
        rst_on();
        mem[0] = 32'h0800_0040;
        push(0, 0);
`ifdef MIPS_MC_JUMP_BNE_EN
        push(0, 32'h100);
        push(0, 32'h100);
        rst_off();
        drain("jump_target");
`else
        rst_off();
        drain("j_fetch");
        repeat (2) @(negedge clk);
        chk("j_illegal", halted, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
